wallace_acc: RTL
================

# wallace_acc

Downstream accumulation stage for `wallaceTree`. It consumes the 16-bit per-cycle partial sum on `wallaceTree.io_data_o`, treats each beat as two's complement, and sign-extends and accumulates a programmed number of beats into a wide accumulator. It then presents the final dot-product result, with a sticky signed-overflow flag, on a valid/ready output port for the MPU result path.

## Interface
- `ACC_W`, default 32: accumulator and result width in bits. Legal range is 17 to 64.
- `LEN_W`, default 8: width of the beat-count field.
- `clock`  in  1  — the single clock. All state updates on its rising edge.
- `reset`  in  1  — synchronous, active-low. `reset == 0` at a rising edge resets the block.
- `io_start`  in  1  — job start strobe. Sampled only in IDLE.
- `io_len`  in  LEN_W  — number of input beats in the job. Captured on an accepted start.
- `io_in_valid`  in  1  — an input beat is present.
- `io_in_ready`  out  1  — the block accepts an input beat.
- `io_in_data`  in  16  — partial sum from `wallaceTree.io_data_o`, signed.
- `io_out_valid`  out  1  — a result is present.
- `io_out_ready`  in  1  — the consumer accepts the result.
- `io_out_data`  out  ACC_W  — accumulated signed result.
- `io_out_ovf`  out  1  — at least one signed overflow occurred during the job.
- `io_busy`  out  1  — the block is not in IDLE.

## Operation
**States:** IDLE, ACC, OUT. State is registered; all outputs are decoded from registered state only.

**IDLE**
- `io_in_ready` = 0, `io_out_valid` = 0.
- On `io_start` = 1:
  - `acc` ← 0, `ovf` ← 0, `cnt` ← `io_len`.
  - If `io_len` == 0, go to OUT; the result is 0 with `ovf` = 0.
  - Otherwise go to ACC.

**ACC**
- `io_in_ready` = 1.
- A beat is accepted when `io_in_valid` && `io_in_ready`. On each accepted beat:
  - `acc` ← `acc` + sext(`io_in_data`, ACC_W), wrapping modulo 2^ACC_W.
  - `cnt` ← `cnt` − 1.
  - `ovf` ← `ovf` | (sign(acc) == sign(addend) && sign(sum) != sign(acc)).
- When the beat accepted has `cnt` == 1, go to OUT.
- Cycles with `io_in_valid` = 0 are bubbles: no state change.

**OUT**
- `io_out_valid` = 1. `io_out_data` = `acc` and `io_out_ovf` = `ovf`, both stable while valid.
- `io_in_ready` = 0.
- On `io_out_ready` = 1, go to IDLE.
- `acc` and `ovf` keep their values until the next accepted start.

**Rules**
- `io_start` outside IDLE is ignored.
- `io_len` is sampled only when a start is accepted.
- `io_busy` = (state != IDLE).
- Reset asserted in any state, including mid-job or while a result is pending:
  - Go to IDLE next cycle; the job and any unconsumed result are discarded.
  - `acc`, `cnt`, `ovf` cleared.

## Timing
**Reset values:** `io_in_ready` = 0, `io_out_valid` = 0, `io_out_data` = 0, `io_out_ovf` = 0, `io_busy` = 0.

**Start**
- Start accepted at edge t. In ACC, `io_in_ready` = 1 from cycle t+1.
- With `io_len` == 0, `io_out_valid` = 1 from cycle t+1.

**Throughput and latency**
- ACC accepts one beat per cycle.
- The last beat is accepted at edge t; `io_out_valid` = 1 from cycle t+1, giving 1-cycle latency.

**Result handshake**
- The result handshake completes at edge t. The block is in IDLE at t+1, and the earliest next start is accepted at edge t+1.
- Minimum job period is `len` + 2 cycles.

**Backpressure**
- `io_out_valid` holds indefinitely while `io_out_ready` = 0.
- No input beat is accepted in OUT.

**Upstream**
- `wallaceTree` is purely combinational. The upstream pipeline drives `io_in_valid` aligned with its operands.

## Test plan
1. len=4, beats 1,2,3,4 with `io_in_valid` held high → `io_out_data`=10, `ovf`=0. Valid asserts exactly 1 cycle after the 4th beat. 6 cycles from start to handshake with `io_out_ready`=1.
2. len=3, beats 0xFFFF×3 → `io_out_data`=0xFFFFFFFD (−3), `ovf`=0. Then len=2, beats 0x8000, 0x7FFF → 0xFFFFFFFF.
3. len=0 → `io_out_valid`=1 the cycle after start, data=0, `ovf`=0. `io_in_ready` stays 0 throughout.
4. Bubbles and backpressure: len=3 with `io_in_valid` toggling 1,0,1,0,1 (beats 5,6,7), then `io_out_ready` held low 5 cycles →
   - result 18 held stable for all 5 cycles;
   - `io_in_ready`=0 during OUT;
   - a `io_start` pulse during OUT is ignored.
5. ACC_W=18, len=5, beats 0x7FFF×5 → `io_out_ovf`=1, `io_out_data`=163835 mod 2^18 = 0x27FFB. The next job (len=1, beat 1) returns 1 with `ovf`=0.
6. Reset (low) after 2 of 4 accepted beats → all outputs 0 and IDLE next cycle. A fresh len=1 job with beat 9 returns 9.

Source files
------------

// File: rtl/wallace_acc.sv
// Accumulation stage behind wallaceTree: sign-extends each 16-bit partial sum,
// accumulates a programmed number of beats and hands the result out on valid/ready.
module wallace_acc #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic [LEN_W-1:0] io_len,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [15:0]      io_in_data,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [ACC_W-1:0] io_out_data,
  output logic             io_out_ovf,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0]        cnt_q;
  logic                    ovf_q;

  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic                    start_acc;
  logic                    beat_acc;

  function automatic logic signed [ACC_W-1:0] sext_beat(input logic [15:0] x);
    return {{(ACC_W-16){x[15]}}, x};
  endfunction

  // Two's complement overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign addend    = sext_beat(io_in_data);
  assign sum       = acc_q + addend;
  assign start_acc = (state_q == IDLE) && io_start;
  assign beat_acc  = (state_q == ACC) && io_in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (io_start) state_d = (io_len == '0) ? OUT : ACC;
      ACC:  if (io_in_valid && (cnt_q == LEN_W'(1))) state_d = OUT;
      OUT:  if (io_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= io_len;
      end else if (beat_acc) begin
        acc_q <= sum;
        cnt_q <= cnt_q - LEN_W'(1);
        ovf_q <= ovf_q | add_ovf(acc_q, addend, sum);
      end
    end
  end

  assign io_in_ready  = (state_q == ACC);
  assign io_out_valid = (state_q == OUT);
  assign io_out_data  = acc_q;
  assign io_out_ovf   = ovf_q;
  assign io_busy      = (state_q != IDLE);

endmodule
